// File: rtl/datapoint_stream_reader.sv
// Read-side master for the datapoint memory: streams a contiguous, wrapping address
// range out as valid/ready beats, hiding the memory's one-cycle read latency.
module datapoint_stream_reader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 18,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_start,
  input  logic [ADDR_WIDTH-1:0] io_baseAddr,
  input  logic [ADDR_WIDTH:0]   io_count,
  output logic                  io_busy,
  output logic                  io_done,
  output logic [ADDR_WIDTH-1:0] io_memAddr,
  output logic                  io_memWrEna,
  input  logic [DATA_WIDTH-1:0] io_memRdData,
  output logic                  io_out_valid,
  input  logic                  io_out_ready,
  output logic [DATA_WIDTH-1:0] io_out_bits,
  output logic                  io_out_last
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [ADDR_WIDTH:0] ONE       = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [2:0]          BUF_LIMIT = 3'(BUF_DEPTH);

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] baseReg;
  logic [ADDR_WIDTH:0]   countReg;
  logic [ADDR_WIDTH:0]   issueCnt;
  logic [ADDR_WIDTH:0]   beatCnt;
  logic [ADDR_WIDTH-1:0] lastAddr;
  logic [DATA_WIDTH-1:0] bufMem [BUF_DEPTH];
  logic                  headPtr;
  logic                  tailPtr;
  logic [1:0]            occ;
  logic                  inflight;

  logic                  pop;
  logic                  issue;
  logic [2:0]            fill;
  logic [ADDR_WIDTH-1:0] issueAddr;

  // A read may only issue if the word it returns is guaranteed a free buffer slot.
  always_comb begin
    pop       = io_out_valid && io_out_ready;
    fill      = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    issue     = (state == READ) && (fill < BUF_LIMIT);
    issueAddr = baseReg + issueCnt[ADDR_WIDTH-1:0];
  end

  assign io_memAddr   = issue ? issueAddr : lastAddr;
  assign io_memWrEna  = 1'b0;
  assign io_busy      = (state == READ) || (state == DRAIN);
  assign io_done      = (state == DONE);
  assign io_out_valid = (occ != 2'd0);
  assign io_out_bits  = bufMem[headPtr];
  assign io_out_last  = io_out_valid && (beatCnt == countReg - ONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      baseReg  <= '0;
      countReg <= '0;
      issueCnt <= '0;
      beatCnt  <= '0;
      lastAddr <= '0;
      headPtr  <= 1'b0;
      tailPtr  <= 1'b0;
      occ      <= 2'd0;
      inflight <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) bufMem[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (io_start) begin
            if (io_count != '0) begin
              baseReg  <= io_baseAddr;
              countReg <= io_count;
              issueCnt <= '0;
              beatCnt  <= '0;
              state    <= READ;
            end else begin
              state <= DONE;
            end
          end
        end
        READ: begin
          if (issue) begin
            issueCnt <= issueCnt + ONE;
            lastAddr <= issueAddr;
            if (issueCnt + ONE == countReg) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && io_out_last) state <= DONE;
        end
        default: state <= IDLE;
      endcase

      // Read data lands one cycle after issue, straight into the buffer tail.
      inflight <= issue;
      if (inflight) begin
        bufMem[tailPtr] <= io_memRdData;
        tailPtr         <= ~tailPtr;
      end
      if (pop) begin
        headPtr <= ~headPtr;
        beatCnt <= beatCnt + ONE;
      end
      occ <= occ + {1'b0, inflight} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_datapoint_stream_reader.sv
// Self-checking bench for datapoint_stream_reader: a synchronous-read memory model plus
// a transfer-level reference (expected word queue, issue/handshake accounting).
module tb_datapoint_stream_reader;

  localparam int AW    = 10;
  localparam int DW    = 18;
  localparam int DEPTH = 1024;

  logic          clock = 1'b0;
  logic          reset;
  logic          ioStart;
  logic [AW-1:0] ioBaseAddr;
  logic [AW:0]   ioCount;
  logic          ioReady;
  logic          busy, done, memWrEna, outValid, outLast;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memRdData, outBits;

  logic [DW-1:0] mem [0:DEPTH-1];

  int assertCount = 0;
  int failCount   = 0;

  datapoint_stream_reader dut (
    .clock        (clock),
    .reset        (reset),
    .io_start     (ioStart),
    .io_baseAddr  (ioBaseAddr),
    .io_count     (ioCount),
    .io_busy      (busy),
    .io_done      (done),
    .io_memAddr   (memAddr),
    .io_memWrEna  (memWrEna),
    .io_memRdData (memRdData),
    .io_out_valid (outValid),
    .io_out_ready (ioReady),
    .io_out_bits  (outBits),
    .io_out_last  (outLast)
  );

  always #5 clock = ~clock;

  // Synchronous-read memory: data for an address appears the cycle after it is presented.
  always @(posedge clock) memRdData <= mem[memAddr];

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; ioStart = 1'b0; ioBaseAddr = '0; ioCount = '0; ioReady = 1'b0;
    nextCycle(); nextCycle();
    @(negedge clock);
    assertCount++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL reset busy: got %0b expected 0", busy); end
    assertCount++; if (done !== 1'b0) begin failCount++; $display("[TB] FAIL reset done: got %0b expected 0", done); end
    assertCount++; if (outValid !== 1'b0) begin failCount++; $display("[TB] FAIL reset valid: got %0b expected 0", outValid); end
    assertCount++; if (outLast !== 1'b0) begin failCount++; $display("[TB] FAIL reset last: got %0b expected 0", outLast); end
    assertCount++; if (memAddr !== '0) begin failCount++; $display("[TB] FAIL reset memAddr: got %0d expected 0", memAddr); end
    assertCount++; if (outBits !== '0) begin failCount++; $display("[TB] FAIL reset bits: got %0h expected 0", outBits); end
    assertCount++; if (memWrEna !== 1'b0) begin failCount++; $display("[TB] FAIL reset memWrEna: got %0b expected 0", memWrEna); end
    nextCycle();
    reset = 1'b0;
    nextCycle();
  endtask

  // Cycle-exact latency check with memory[i] = i + 100.
  task automatic test_basic_latency();
    logic [DW-1:0] expBits;
    ioStart = 1'b1; ioBaseAddr = AW'(5); ioCount = (AW+1)'(4); ioReady = 1'b1;
    @(negedge clock);
    assertCount++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL basic busy0: got %0b expected 0", busy); end
    nextCycle();
    ioStart = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      expBits = DW'(c + 102);
      assertCount++; if (outValid !== (c >= 3 && c <= 6)) begin failCount++; $display("[TB] FAIL basic valid c%0d: got %0b expected %0b", c, outValid, (c >= 3 && c <= 6)); end
      if (c >= 3 && c <= 6) begin
        assertCount++; if (outBits !== expBits) begin failCount++; $display("[TB] FAIL basic bits c%0d: got %0d expected %0d", c, outBits, expBits); end
      end
      assertCount++; if (outLast !== (c == 6)) begin failCount++; $display("[TB] FAIL basic last c%0d: got %0b expected %0b", c, outLast, (c == 6)); end
      assertCount++; if (done !== (c == 7)) begin failCount++; $display("[TB] FAIL basic done c%0d: got %0b expected %0b", c, done, (c == 7)); end
      assertCount++; if (busy !== (c <= 6)) begin failCount++; $display("[TB] FAIL basic busy c%0d: got %0b expected %0b", c, busy, (c <= 6)); end
      if (c <= 4) begin
        assertCount++; if (memAddr !== AW'(c + 4)) begin failCount++; $display("[TB] FAIL basic memAddr c%0d: got %0d expected %0d", c, memAddr, c + 4); end
      end
      nextCycle();
    end
  endtask

  // Generic transfer scenario: mode 0 = ready high, 1 = 1,0,0,1,0,1 pattern, 2 = random.
  task automatic test_stream(input string name, input int base, input int cnt, input int mode, input int restartAt);
    logic [DW-1:0] expQ[$];
    logic [DW-1:0] prevBits;
    logic          prevLast;
    logic [AW-1:0] lastAddr;
    int            pattern[6] = '{1, 0, 0, 1, 0, 1};
    int            issued = 0;
    int            hs = 0;
    int            lastHsCyc = -10;
    int            budget = 20 * cnt + 20;
    bit            prevStall = 1'b0;
    bit            doneSeen = 1'b0;
    bit            doneExp;
    for (int i = 0; i < cnt; i++) expQ.push_back(mem[(base + i) % DEPTH]);
    lastAddr = memAddr;
    ioStart = 1'b1; ioBaseAddr = AW'(base); ioCount = (AW+1)'(cnt); ioReady = 1'b1;
    @(negedge clock);
    assertCount++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL %s busy0: got %0b expected 0", name, busy); end
    nextCycle();
    for (int cyc = 1; cyc <= budget && !doneSeen; cyc++) begin
      ioStart = (cyc == restartAt);
      if (cyc == restartAt) begin ioBaseAddr = AW'(base + 300); ioCount = (AW+1)'(5); end
      case (mode)
        0:       ioReady = 1'b1;
        1:       ioReady = pattern[(cyc - 1) % 6] != 0;
        default: ioReady = 1'($urandom_range(0, 1));
      endcase
      @(negedge clock);
      if (cyc == 1 || memAddr !== lastAddr) begin
        issued++;
        assertCount++; if (memAddr !== AW'((base + issued - 1) % DEPTH)) begin failCount++; $display("[TB] FAIL %s memAddr issue%0d: got %0d expected %0d", name, issued, memAddr, (base + issued - 1) % DEPTH); end
        lastAddr = memAddr;
      end
      assertCount++; if (issued > cnt) begin failCount++; $display("[TB] FAIL %s overissue: got %0d expected <= %0d", name, issued, cnt); end
      assertCount++; if (busy !== (hs < cnt)) begin failCount++; $display("[TB] FAIL %s busy c%0d: got %0b expected %0b", name, cyc, busy, (hs < cnt)); end
      doneExp = (hs == cnt) && (lastHsCyc == cyc - 1);
      assertCount++; if (done !== doneExp) begin failCount++; $display("[TB] FAIL %s done c%0d: got %0b expected %0b", name, cyc, done, doneExp); end
      if (doneExp) doneSeen = 1'b1;
      if (prevStall) begin
        assertCount++; if (outValid !== 1'b1 || outBits !== prevBits || outLast !== prevLast) begin failCount++; $display("[TB] FAIL %s stall_hold c%0d: got %0b/%0h/%0b expected 1/%0h/%0b", name, cyc, outValid, outBits, outLast, prevBits, prevLast); end
      end
      if (outValid === 1'b1 && ioReady) begin
        assertCount++;
        if (hs >= cnt) begin failCount++; $display("[TB] FAIL %s extra_beat: got beat %0d expected %0d beats", name, hs + 1, cnt); end
        else if (outBits !== expQ[hs] || outLast !== (hs == cnt - 1)) begin failCount++; $display("[TB] FAIL %s beat%0d: got %0h/%0b expected %0h/%0b", name, hs, outBits, outLast, expQ[hs], (hs == cnt - 1)); end
        hs++;
        lastHsCyc = cyc;
      end
      assertCount++; if (issued - hs > 2) begin failCount++; $display("[TB] FAIL %s outstanding c%0d: got %0d expected <= 2", name, cyc, issued - hs); end
      prevStall = (outValid === 1'b1) && !ioReady;
      prevBits  = outBits;
      prevLast  = outLast;
      nextCycle();
    end
    ioStart = 1'b0;
    assertCount++; if (!doneSeen) begin failCount++; $display("[TB] FAIL %s timeout: got no done expected done within %0d cycles", name, budget); end
    assertCount++; if (hs != cnt) begin failCount++; $display("[TB] FAIL %s beats: got %0d expected %0d", name, hs, cnt); end
    assertCount++; if (issued != cnt) begin failCount++; $display("[TB] FAIL %s issues: got %0d expected %0d", name, issued, cnt); end
    @(negedge clock);
    assertCount++; if (done !== 1'b0 || busy !== 1'b0) begin failCount++; $display("[TB] FAIL %s after_done: got done=%0b busy=%0b expected 0/0", name, done, busy); end
    nextCycle();
  endtask

  task automatic test_wrap();
    test_stream("wrap", 1022, 4, 0, 0);
  endtask

  task automatic test_backpressure();
    test_stream("backpressure", int'($urandom_range(0, DEPTH - 1)), 3, 1, 0);
  endtask

  task automatic test_ignore_start();
    test_stream("ignore_start", int'($urandom_range(0, DEPTH - 1)), 8, 2, 4);
  endtask

  task automatic test_zero_count();
    logic [AW-1:0] prevAddr;
    prevAddr = memAddr;
    ioStart = 1'b1; ioBaseAddr = AW'($urandom_range(0, DEPTH - 1)); ioCount = '0; ioReady = 1'b1;
    nextCycle();
    ioStart = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clock);
      assertCount++; if (done !== (c == 1)) begin failCount++; $display("[TB] FAIL zero done c%0d: got %0b expected %0b", c, done, (c == 1)); end
      assertCount++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL zero busy c%0d: got %0b expected 0", c, busy); end
      assertCount++; if (outValid !== 1'b0) begin failCount++; $display("[TB] FAIL zero valid c%0d: got %0b expected 0", c, outValid); end
      assertCount++; if (memAddr !== prevAddr) begin failCount++; $display("[TB] FAIL zero memAddr c%0d: got %0d expected %0d", c, memAddr, prevAddr); end
      nextCycle();
    end
  endtask

  task automatic test_mid_reset();
    int base;
    base = int'($urandom_range(0, DEPTH - 1));
    ioStart = 1'b1; ioBaseAddr = AW'(base); ioCount = (AW+1)'(6); ioReady = 1'b1;
    nextCycle();
    ioStart = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clock);
      if (c >= 3) begin
        assertCount++; if (outValid !== 1'b1 || outBits !== mem[(base + c - 3) % DEPTH]) begin failCount++; $display("[TB] FAIL midreset beat c%0d: got %0b/%0h expected 1/%0h", c, outValid, outBits, mem[(base + c - 3) % DEPTH]); end
      end
      nextCycle();
    end
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    for (int c = 6; c <= 8; c++) begin
      @(negedge clock);
      assertCount++; if (done !== 1'b0 || busy !== 1'b0) begin failCount++; $display("[TB] FAIL midreset done/busy c%0d: got %0b/%0b expected 0/0", c, done, busy); end
      assertCount++; if (outValid !== 1'b0 || outLast !== 1'b0) begin failCount++; $display("[TB] FAIL midreset valid/last c%0d: got %0b/%0b expected 0/0", c, outValid, outLast); end
      assertCount++; if (memAddr !== '0 || outBits !== '0) begin failCount++; $display("[TB] FAIL midreset addr/bits c%0d: got %0d/%0h expected 0/0", c, memAddr, outBits); end
      nextCycle();
    end
    test_stream("post_reset", 0, 2, 0, 0);
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 5; t++)
      test_stream("back_to_back", int'($urandom_range(0, DEPTH - 1)), (t == 0) ? 1 : int'($urandom_range(2, 40)), 2, 0);
    test_stream("max_count", int'($urandom_range(0, DEPTH - 1)), DEPTH, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i + 100);
    test_reset();
    test_basic_latency();
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
    test_wrap();
    test_backpressure();
    test_zero_count();
    test_ignore_start();
    test_mid_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
